morse_key_capture: RTL and testbench
====================================

# morse_key_capture

Front-end keyer stage for the Morse communicator. Samples a raw push-button, debounces it, classifies each press as dot or dash by duration, and accumulates up to four symbols. On a letter gap it presents the completed 8-bit code word with a ready strobe. It sits directly upstream of the Morse-to-7-segment decoder and drives that stage's `morse_array` and `new_input_ready` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronized samples required to change the debounced key level.
- `DASH_MIN_CYCLES`, default 15000000: minimum debounced-high length (cycles) classified as dash; shorter is dot.
- `LETTER_GAP_CYCLES`, default 30000000: debounced-low length after the last release that ends a letter.
- `PULSE_CYCLES`, default 4: width of the `new_input_ready` strobe, ≥1.
- `clk  input  1  system clock; all state on rising edge.`
- `rst_n  input  1  asynchronous, active-low reset.`
- `key_in  input  1  raw asynchronous button, active high.`
- `morse_array  output  8  completed code word, 2 bits/symbol: 01 = dot, 10 = dash, 00 = empty; last symbol in [1:0], first symbol in highest occupied pair.`
- `new_input_ready  output  1  high for PULSE_CYCLES cycles per emitted letter.`
- `symbol_count  output  3  symbols accumulated in current letter, 0..4.`
- `overflow  output  1  one-cycle pulse when a 5th symbol is committed (letter discarded).`

## Operation
- `key_in` passes through a 2-flop synchronizer, then a debouncer. The debounced level `key_db` toggles on the DEBOUNCE_CYCLES-th consecutive cycle the synchronized value differs from `key_db`. Any agreeing sample clears the count.
- Accumulator `shift_acc[7:0]`. On commit, `shift_acc <= {shift_acc[5:0], sym}` and `symbol_count` increments.
- Press counter counts cycles with `key_db` high and saturates at DASH_MIN_CYCLES. At the falling edge of `key_db`, the symbol is dash if counter = DASH_MIN_CYCLES, else dot.
- FSM states:
  - IDLE: `symbol_count` = 0, key released. Rise of `key_db` → PRESS.
  - PRESS: counting. Fall of `key_db` → commit the symbol. If the commit would be the 5th symbol: assert `overflow`, clear `shift_acc` and `symbol_count`, go to IDLE. Otherwise → GAP.
  - GAP: the gap counter clears on entry and counts low cycles. Rise of `key_db` → PRESS (same letter). When the counter reaches LETTER_GAP_CYCLES → EMIT.
  - EMIT: single cycle. `morse_array <= shift_acc`, clear `shift_acc` and `symbol_count`, start the pulse timer. → IDLE. A rise of `key_db` in this cycle moves to PRESS instead; it starts the next letter.
- Simultaneous rise of `key_db` and the gap counter reaching its threshold: the rise wins, and the symbol extends the current letter.
- The pulse timer is independent of the FSM. `new_input_ready` is high for PULSE_CYCLES cycles and does not block new presses.
- `morse_array` changes only in EMIT. It holds its value through later letters' accumulation and through overflows.

## Timing
- Reset values are all 0: `morse_array`, `new_input_ready`, `symbol_count`, `overflow`, `key_db`, FSM = IDLE, all counters. Reset mid-letter discards the partial letter.
- A key held across reset release debounces high after DEBOUNCE_CYCLES+2 cycles and is treated as a fresh press.
- `morse_array` is registered in EMIT. `new_input_ready` rises on the following cycle, so data is stable one full cycle before the strobe edge and for the whole strobe.
- Emit latency: EMIT is entered LETTER_GAP_CYCLES cycles after the `key_db` fall. Strobe rise follows one cycle later.
- Dot/dash boundary: a `key_db` high time of DASH_MIN_CYCLES−1 gives a dot; DASH_MIN_CYCLES gives a dash.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

## Test plan
Bench parameters: DEBOUNCE=4, DASH_MIN=20, GAP=30, PULSE=2.
- Reset: hold `rst_n` low with `key_in` toggling → all outputs 0. Release → outputs stay 0 with the key idle.
- `key_db` high 10 cycles then released → 31 cycles after the fall, `morse_array`=00000001 and `new_input_ready` high for exactly 2 cycles; `symbol_count` returns to 0.
- Presses of 25, 10, 10, 10 cycles separated by 10-cycle gaps → `morse_array`=10010101 (B), one strobe.
- Boundary: press 19 → dot; press 20 → dash. Press 10, gap 29, press 25 → single letter 00000110 (A). A gap of exactly 30 instead → two letters, E then T (00000010).
- Five dots with 10-cycle gaps → `overflow` pulses once on the 5th release, no strobe, and `morse_array` keeps its previous value.
- `key_in` glitches of 3 cycles produce no `key_db` change and no symbol. `rst_n` asserted mid-press after 2 committed symbols → next letter starts from `symbol_count`=0.

Source files
------------

// File: rtl/morse_key_capture_if.sv
// morse_key_capture_if: code-word bus from the keyer to the Morse decoder
interface morse_key_capture_if;
  logic [7:0] morse_array;
  logic       new_input_ready;
  logic [2:0] symbol_count;
  logic       overflow;
  modport master(output morse_array, new_input_ready, symbol_count, overflow);
  modport slave(input morse_array, new_input_ready, symbol_count, overflow);
endinterface

// File: rtl/morse_key_capture.sv
// morse_key_capture: debounces a key, classifies dot/dash and emits 4-symbol code words
module morse_key_capture #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned DASH_MIN_CYCLES   = 15000000,
  parameter int unsigned LETTER_GAP_CYCLES = 30000000,
  parameter int unsigned PULSE_CYCLES      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_in,
  morse_key_capture_if.master        bus
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PRW = $clog2(DASH_MIN_CYCLES + 1);
  localparam int GPW = $clog2(LETTER_GAP_CYCLES + 1);
  localparam int PLW = $clog2(PULSE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRW-1:0] DASH_MAX = PRW'(DASH_MIN_CYCLES);
  localparam logic [GPW-1:0] GAP_MAX  = GPW'(LETTER_GAP_CYCLES);
  localparam logic [PLW-1:0] PULSE_LD = PLW'(PULSE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  state_t         state;
  logic [1:0]     sync;
  logic           key_db, key_db_q;
  logic [DBW-1:0] db_cnt;
  logic [PRW-1:0] press_cnt;
  logic [GPW-1:0] gap_cnt;
  logic [PLW-1:0] pulse_cnt;
  logic [7:0]     shift_acc;
  logic           rise, fall;
  logic [1:0]     sym;
  logic [GPW-1:0] gap_nxt;

  assign rise    = key_db & ~key_db_q;
  assign fall    = ~key_db & key_db_q;
  assign sym     = press_cnt == DASH_MAX ? 2'b10 : 2'b01;
  assign gap_nxt = gap_cnt + GPW'(1);

  // synchronize the raw key and toggle key_db after DEBOUNCE_CYCLES disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync     <= 2'b00;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync     <= {sync[0], key_in};
      key_db_q <= key_db;
      db_cnt   <= (sync[1] == key_db || db_cnt == DB_LAST) ? '0 : db_cnt + DBW'(1);
      if (sync[1] != key_db && db_cnt == DB_LAST) key_db <= ~key_db;
    end

  // letter FSM: edges of key_db are seen one cycle late, so both counters start at 1 to include that cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      press_cnt        <= '0;
      gap_cnt          <= '0;
      shift_acc        <= '0;
      bus.symbol_count <= '0;
      bus.overflow     <= 1'b0;
      bus.morse_array  <= '0;
    end else begin
      bus.overflow <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          state     <= PRESS;
          press_cnt <= PRW'(1);
        end
        PRESS: begin
          if (press_cnt != DASH_MAX) press_cnt <= press_cnt + PRW'(1);
          if (fall && bus.symbol_count == 3'd4) begin
            bus.overflow     <= 1'b1;
            shift_acc        <= '0;
            bus.symbol_count <= '0;
            state            <= IDLE;
          end else if (fall) begin
            shift_acc        <= {shift_acc[5:0], sym};
            bus.symbol_count <= bus.symbol_count + 3'd1;
            gap_cnt          <= GPW'(1);
            state            <= GAP;
          end
        end
        GAP: if (rise) begin
          state     <= PRESS;
          press_cnt <= PRW'(1);
        end else begin
          gap_cnt <= gap_nxt;
          if (gap_nxt == GAP_MAX) state <= EMIT;
        end
        default: begin
          bus.morse_array  <= shift_acc;
          shift_acc        <= '0;
          bus.symbol_count <= '0;
          state            <= rise ? PRESS : IDLE;
          press_cnt        <= PRW'(1);
        end
      endcase
    end

  // ready strobe runs on its own timer, rising the cycle after the word is latched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse_cnt           <= '0;
      bus.new_input_ready <= 1'b0;
    end else begin
      pulse_cnt           <= state == EMIT ? PULSE_LD : (pulse_cnt != '0 ? pulse_cnt - PLW'(1) : '0);
      bus.new_input_ready <= pulse_cnt != '0;
    end
endmodule

// File: tb/tb_morse_key_capture.sv
// tb_morse_key_capture: scoreboard bench for the Morse key capture front end
module tb_morse_key_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_letters[$];
  logic [7:0] exp_ovf[$];
  logic nir_q = 1'b0;
  int width = 0;

  always #5 clk = ~clk;

  morse_key_capture_if bus();

  morse_key_capture #(
    .DEBOUNCE_CYCLES(4),
    .DASH_MIN_CYCLES(20),
    .LETTER_GAP_CYCLES(30),
    .PULSE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    idle(n);
    key_in = 1'b0;
  endtask

  // monitor: pops the scoreboard on each strobe rise and each overflow pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      nir_q = 1'b0;
      width = 0;
    end else begin
      if (bus.new_input_ready) width++;
      if (bus.new_input_ready && !nir_q) begin
        check("strobe_expected", exp_letters.size() > 0, 1);
        if (exp_letters.size() > 0) check("letter", bus.morse_array, exp_letters.pop_front());
      end
      if (!bus.new_input_ready && nir_q) begin
        check("strobe_width", width, 2);
        width = 0;
      end
      if (bus.overflow) begin
        check("overflow_expected", exp_ovf.size() > 0, 1);
        if (exp_ovf.size() > 0) check("overflow_hold", bus.morse_array, exp_ovf.pop_front());
      end
      nir_q = bus.new_input_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] sc;
    for (int i = 0; i < 6; i++) begin
      key_in = i[0];
      @(negedge clk);
      check("reset_outputs", {bus.morse_array, bus.new_input_ready, bus.symbol_count, bus.overflow}, 0);
    end
    key_in = 1'b0;
    rst_n = 1'b1;
    idle(10);
    check("idle_outputs", {bus.morse_array, bus.new_input_ready, bus.symbol_count, bus.overflow}, 0);
    exp_letters.push_back(8'b00000001);
    press(10);
    n = 0;
    sc = 3'd0;
    while (bus.morse_array != 8'h01 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) sc = bus.symbol_count;
    end
    check("symbol_count_mid", sc, 1);
    check("emit_latency", n, 37);
    check("strobe_low_at_emit", bus.new_input_ready, 0);
    @(posedge clk);
    #1;
    check("strobe_rise", bus.new_input_ready, 1);
    check("symbol_count_clear", bus.symbol_count, 0);
    idle(20);
    exp_letters.push_back(8'b10010101);
    press(25); idle(10);
    press(10); idle(10);
    press(10); idle(10);
    press(10); idle(50);
    exp_letters.push_back(8'b00000001);
    press(19); idle(50);
    exp_letters.push_back(8'b00000010);
    press(20); idle(50);
    exp_letters.push_back(8'b00000110);
    press(10); idle(29);
    press(25); idle(50);
    exp_letters.push_back(8'b00000001);
    exp_letters.push_back(8'b00000010);
    press(10); idle(30);
    press(25); idle(50);
    exp_ovf.push_back(8'b00000010);
    for (int i = 0; i < 5; i++) begin
      press(10);
      idle(10);
    end
    idle(50);
    check("overflow_morse_hold", bus.morse_array, 8'b00000010);
    check("overflow_count_clear", bus.symbol_count, 0);
    press(3); idle(3);
    press(3); idle(50);
    check("glitch_key_db", dut.key_db, 0);
    check("glitch_count", bus.symbol_count, 0);
    press(10); idle(10);
    press(10); idle(8);
    check("two_symbols", bus.symbol_count, 2);
    key_in = 1'b1;
    idle(8);
    rst_n = 1'b0;
    key_in = 1'b0;
    idle(3);
    check("midpress_reset", {bus.morse_array, bus.symbol_count}, 0);
    rst_n = 1'b1;
    idle(5);
    exp_letters.push_back(8'b00000010);
    press(25);
    idle(10);
    check("count_after_reset", bus.symbol_count, 1);
    idle(50);
    check("letters_pending", exp_letters.size(), 0);
    check("overflow_pending", exp_ovf.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
